muldiv_seq: RTL
===============

# muldiv_seq

Multi-cycle unsigned multiply/divide sequencer for the 16-bit CPU datapath. Given a start pulse from the control path, it accepts two operands and iterates one shift-add (multiply) or restore-subtract (divide) step per clock. It then returns a double-width result to the register-file write-back mux, using a start/busy/done handshake. Single-cycle ALU operations bypass it; the control unit stalls fetch while `busy` is high.

## Interface

**Parameters**
- `WIDTH`, default 16: operand width; results are 2×WIDTH split over two ports.

**Ports**
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_b` input, 1 bit: reset, synchronous and active-low.
- `start` input, 1 bit: request; sampled only when not busy.
- `op` input, 1 bit: 0 = multiply, 1 = divide.
- `opa` input, WIDTH bits: multiplicand or dividend.
- `opb` input, WIDTH bits: multiplier or divisor.
- `busy` output, 1 bit: operation in progress.
- `done` output, 1 bit: one-cycle completion pulse.
- `res_hi` output, WIDTH bits: multiply gives product[2W-1:W]; divide gives remainder.
- `res_lo` output, WIDTH bits: multiply gives product[W-1:0]; divide gives quotient.
- `div_zero` output, 1 bit: last divide had a zero divisor.

## Operation

**FSM: IDLE → RUN → DONE.**
- **IDLE**
  - `start=1` latches `op`, `opa`, `opb` into working registers, loads the iteration counter with WIDTH, and moves to RUN.
  - Divide with `opb==0` moves straight to DONE instead.
- **RUN**
  - One iteration per cycle; the counter decrements.
  - On the last iteration (counter==1), go to DONE.
- **DONE**
  - `done=1` for exactly this cycle.
  - `res_hi`, `res_lo` and `div_zero` update at the edge entering DONE.
  - Next state is IDLE. A `start` sampled in DONE is accepted as if in IDLE (back-to-back operation) and goes to RUN.

**Arithmetic**
- Multiply: unsigned shift-add, LSB-first; 2W-bit accumulator; carry out of the W-bit adder is kept.
- Divide: unsigned restoring division.
  - Each step shifts {rem, quot} left by one, then trial-subtracts the divisor over W+1 bits.
  - Result non-negative: keep the difference and set the quotient bit.
- Divide by zero: quotient = all ones, remainder = `opa`, `div_zero=1`.

**Result holding**
- `res_hi`/`res_lo` are separate from the working registers.
- They hold their previous values throughout RUN and change only on entering DONE.
- `div_zero` is cleared by any completed multiply or nonzero-divisor divide.

**Boundary and error cases**
- `start` during RUN is ignored: no queuing, and operands do not change.
- `rst_b=0` at any edge, including mid-RUN: go to IDLE; `busy`, `done`, `div_zero`, `res_hi`, `res_lo` all 0; no `done` pulse for the aborted operation.
- Operand inputs only need to be valid in the `start` cycle.

## Timing

- Reset values: `busy=0`, `done=0`, `res_hi=0`, `res_lo=0`, `div_zero=0`; state is IDLE.
- Edge numbering: `start` sampled at edge 0.
  - `busy=1` in cycles 1..WIDTH.
  - `done=1` in cycle WIDTH+1, with `busy=0` in that cycle.
  - Latency is WIDTH+1 cycles (17 at default).
- Divide by zero: `done=1` in cycle 1 and `busy` never asserts; latency is 1.
- Back-to-back: a `start` held through the DONE cycle yields `done` every WIDTH+1 cycles.
- `busy` and `done` are registered outputs, not combinational from `start`.

## Configuration

- **`MULDIV_DIV_EN` defined**
  - Divide path, divisor-zero detect and `div_zero` register are compiled in; `op` selects the operation.
- **Not defined**
  - Multiply-only: `op` is ignored and treated as 0, and `div_zero` is tied to 0.
  - Subtractor, restore mux and zero-detect are absent.
  - Timing is unchanged.

## Test plan

1. **Reset:** hold `rst_b=0` two cycles, release. Required: all outputs 0; `busy` stays 0 with `start=0`.
2. **Multiply:** 0x00FF × 0x0101. Required: `busy` in cycles 1–16; `done` in cycle 17; `res_hi=0x0000`, `res_lo=0xFFFF`.
3. **Multiply max:** 0xFFFF × 0xFFFF. Required: `res_hi=0xFFFE`, `res_lo=0x0001`; results are unchanged (previous values) during RUN.
4. **Divide:** 0x8001 / 0x0010. Required: `res_lo=0x0800`, `res_hi=0x0001`, `div_zero=0`, `done` in cycle 17. Without `MULDIV_DIV_EN`, the same stimulus gives the product: `res_hi=0x0008`, `res_lo=0x0010`.
5. **Divide by zero:** 0x1234 / 0. Required: `done` in cycle 1, `busy` never 1; `res_lo=0xFFFF`, `res_hi=0x1234`, `div_zero=1`. A following multiply 2×3 clears `div_zero` and gives `res_lo=0x0006`.
6. **Busy start and mid-op reset:**
   - Start 5×7, pulse `start` with 9×9 in cycle 4. Required: `res_lo=0x0023`.
   - Start again and assert `rst_b=0` in cycle 8. Required: IDLE next cycle, all outputs 0, no `done` pulse.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake and operand/result bundle between the control path and muldiv_seq.
// The master side (control unit) drives the request; the slave side (sequencer)
// returns status and results.
interface muldiv_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             div_zero;

   modport master (
      output start, op, opa, opb,
      input  busy, done, res_hi, res_lo, div_zero
   );

   modport slave (
      input  start, op, opa, opb,
      output busy, done, res_hi, res_lo, div_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer: one shift-add or restoring
// subtract step per clock, start/busy/done handshake, double-width result.
// Define MULDIV_DIV_EN to compile in the divide path; otherwise multiply-only
// with op ignored and div_zero tied low. WIDTH must match the interface WIDTH.
module muldiv_seq #(
   parameter int unsigned WIDTH = 16
) (
   input logic         clk,
   input logic         rst_b,
   muldiv_seq_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   state_e           state;
   logic [CntW-1:0]  cnt;
   // work_hi: accumulator high half / partial remainder
   // work_lo: multiplier being shifted out / dividend becoming quotient
   // work_b : multiplicand / divisor
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;
   logic [WIDTH-1:0] work_b;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] res_hi_q;
   logic [WIDTH-1:0] res_lo_q;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic             start_dz;

   // One multiply step: conditional add keeping the carry, then shift the
   // 2W+1-bit {carry, sum, multiplier} right by one.
   always_comb begin
      mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, work_b} : {(WIDTH + 1){1'b0}});
      mul_hi  = mul_sum[WIDTH:1];
      mul_lo  = {mul_sum[0], work_lo[WIDTH-1:1]};
   end

`ifdef MULDIV_DIV_EN
   logic             is_div_q;
   logic             div_zero_q;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] div_hi;
   logic [WIDTH-1:0] div_lo;

   // One restoring-divide step: shift {rem, quot} left, trial-subtract over
   // W+1 bits, keep the difference when it did not go negative.
   always_comb begin
      div_diff = {work_hi, work_lo[WIDTH-1]} - {1'b0, work_b};
      if (!div_diff[WIDTH]) begin
         div_hi = div_diff[WIDTH-1:0];
         div_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
         div_hi = {work_hi[WIDTH-2:0], work_lo[WIDTH-1]};
         div_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
   end

   // Select the step for the latched operation.
   always_comb begin
      step_hi = is_div_q ? div_hi : mul_hi;
      step_lo = is_div_q ? div_lo : mul_lo;
   end

   assign start_dz     = bus.op && (bus.opb == '0);
   assign bus.div_zero = div_zero_q;
`else
   logic unused_op;

   // Multiply-only build: always take the shift-add step.
   always_comb begin
      step_hi = mul_hi;
      step_lo = mul_lo;
   end

   assign unused_op    = bus.op;
   assign start_dz     = 1'b0;
   assign bus.div_zero = 1'b0;
`endif

   // Sequencer FSM with registered busy/done/results.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state    <= StIdle;
         cnt      <= '0;
         work_hi  <= '0;
         work_lo  <= '0;
         work_b   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
`ifdef MULDIV_DIV_EN
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state)
            // DONE accepts a new start exactly like IDLE (back-to-back).
            StIdle, StDone: begin
               if (bus.start) begin
                  work_hi <= '0;
                  work_lo <= bus.opa;
                  work_b  <= bus.opb;
                  cnt     <= CntW'(WIDTH);
`ifdef MULDIV_DIV_EN
                  is_div_q <= bus.op;
`endif
                  if (start_dz) begin
                     state    <= StDone;
                     done_q   <= 1'b1;
                     res_hi_q <= bus.opa;
                     res_lo_q <= '1;
`ifdef MULDIV_DIV_EN
                     div_zero_q <= 1'b1;
`endif
                  end else begin
                     state  <= StRun;
                     busy_q <= 1'b1;
                  end
               end else begin
                  state <= StIdle;
               end
            end
            StRun: begin
               work_hi <= step_hi;
               work_lo <= step_lo;
               cnt     <= cnt - 1'b1;
               if (cnt == CntW'(1)) begin
                  state    <= StDone;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  res_hi_q <= step_hi;
                  res_lo_q <= step_lo;
`ifdef MULDIV_DIV_EN
                  div_zero_q <= 1'b0;
`endif
               end
            end
            default: begin
               state  <= StIdle;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.res_hi = res_hi_q;
   assign bus.res_lo = res_lo_q;
endmodule
